id_ex_pipe_stage: RTL and testbench
===================================

Name: id_ex_pipe_stage

Overview:
- Parametrised ID→EX pipeline register. It replaces the free-running ID/EX latch with a valid/ready handshaked stage.
- Adds three behaviours:
  - stall/backpressure, so the stage holds data while EX is busy;
  - flush, which kills the entry on a branch/jump redirect;
  - hazard-bubble insertion, for load-use hazards.
- Sits between the decode/register-file read logic and the EX stage (ALU/forwarding).

Parameters:
- XLEN, 32, register data width (rs1/rs2 data, imm).
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width.
- RADDR_W, 5, register index width.
- CTRL_W, 6, control bundle width; bit map {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}, MSB..LSB.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  ID presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- ctrl_in  in  CTRL_W  decoded control bundle.
- rs1_data_in, rs2_data_in, imm_in  in  XLEN each  operands from ID.
- pc_in  in  ADDR_W  instruction address.
- inst_in  in  INST_W  raw instruction.
- rd_in, rs1_in, rs2_in  in  RADDR_W each  register indices.
- flush  in  1  kill all held and incoming entries (redirect from EX/MEM).
- bubble  in  1  hazard unit requests a NOP into EX; ID must hold.
- out_valid  out  1  EX payload valid.
- out_ready  in  1  EX accepts this cycle.
- ctrl_out, rs1_data_out, rs2_data_out, imm_out, pc_out, inst_out, rd_out, rs1_out, rs2_out  out  same widths as inputs  registered payload.
- occupancy  out  2  number of entries held (0..2).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, ctrl_out=0, all data/index outputs=0, occupancy=0.
  - Skid entry cleared.
  - in_ready=0 during the reset cycle.
- Priority per cycle: reset > flush > bubble > normal handshake.
- Transfer rules:
  - In-transfer when in_valid & in_ready.
  - Out-transfer when out_valid & out_ready.
  - Latency 1 cycle: an accepted beat is visible on the outputs the next cycle when the stage was empty or draining.
- Normal: in_ready = !out_valid | out_ready (combinational, no skid); on in-transfer all fields load together.
- Out-transfer without in-transfer: out_valid<=0 and ctrl_out<=0. Data fields keep their last value.
- Invariant: ctrl_out==0 whenever out_valid==0, so an invalid slot is a safe NOP for EX and MEM.
- flush=1:
  - out_valid<=0, ctrl_out<=0, skid entry dropped, occupancy<=0.
  - Any same-cycle in-transfer is discarded.
  - in_ready forced 0 that cycle.
- bubble=1 (flush=0):
  - in_ready forced 0.
  - If the held entry is accepted (out_ready=1) or the stage is empty: out_valid<=0, ctrl_out<=0.
  - Otherwise the held entry stays unchanged; a bubble never overwrites an unconsumed valid entry.
- Backpressure (out_valid=1, out_ready=0): outputs stable and in_ready=0 (non-skid build).
- Simultaneous in-transfer and out-transfer: new beat replaces old, out_valid stays 1, occupancy unchanged.
- Register indices rs1_out/rs2_out/rd_out are valid only with out_valid; forwarding logic must qualify with out_valid.

Optional Feature:
- Macro: ID_EX_SKID_EN.
- Defined:
  - Adds a second (skid) entry.
  - in_ready = !skid_valid & !bubble & !flush, a registered-only term that breaks the combinational ready path from EX to ID.
  - An in-transfer while the main entry is stalled lands in skid; occupancy=2.
  - On the next out-transfer, skid moves to main; FIFO order is preserved.
  - Flush drops both entries.
- Undefined:
  - Single entry; behaviour as above.
  - occupancy never exceeds 1.

Decomposition:
- Shared package rv_pipe_pkg (existing const header):
  - CTRL_W and the control bit index constants (CTRL_BRANCH..CTRL_REGWRITE);
  - XLEN/ADDR_W/INST_W/RADDR_W defaults;
  - NOP ctrl constant (all zero).
- Payload concatenated internally into one PAYLOAD_W vector.
- One sub-module: pipe_skid_buf (generic PAYLOAD_W-wide 1/2-entry valid/ready buffer). It is instantiated only under ID_EX_SKID_EN, and is reusable for IF/ID, EX/MEM and MEM/WB.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, ctrl_in=6'b111111 → out_valid=0, ctrl_out=0, all outputs 0, occupancy=0.
- Streaming: out_ready=1; send pc 0x00,0x04,0x08 back-to-back → pc_out equals each value one cycle later, out_valid high 3 cycles, in_ready stays 1.
- Backpressure: hold out_ready=0 for 3 cycles with pc 0x10 held → pc_out stays 0x10, in_ready=0 (non-skid), payload stable; release → next beat 0x14 appears the cycle after.
- Flush: held entry pc 0x20 with a new beat 0x24 offered and flush=1 → next cycle out_valid=0, ctrl_out=0; 0x24 is never emitted.
- Bubble: load at pc 0x30 accepted, then bubble=1 for 1 cycle with in_valid=1 (pc 0x34) → one cycle out_valid=0 with ctrl_out=0, then 0x34 emitted; no beat lost or duplicated.
- Skid (ID_EX_SKID_EN): out_ready=0, in_ready=1 accepts 0x40 then 0x44 → occupancy=2, in_ready=0; release out_ready → 0x40 then 0x44 in order; flush at occupancy=2 → occupancy=0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants: default widths, control bundle bit map and the NOP bundle.
package rv_pipe_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned INST_W  = 32;
   localparam int unsigned RADDR_W = 5;
   localparam int unsigned CTRL_W  = 6;

   // Control bundle bit positions, MSB..LSB
   localparam int unsigned CTRL_BRANCH   = 5;
   localparam int unsigned CTRL_MEMREAD  = 4;
   localparam int unsigned CTRL_MEMTOREG = 3;
   localparam int unsigned CTRL_MEMWRITE = 2;
   localparam int unsigned CTRL_ALUSRC   = 1;
   localparam int unsigned CTRL_REGWRITE = 0;

   // An all-zero bundle writes nothing and touches no memory
   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline buffer. SKID=1 gives a second entry so that in_ready
// depends only on registered state; SKID=0 is a plain single-entry register slice.
// flush drops every held entry. Data of an emptied main entry is retained.
module pipe_skid_buf #(
   parameter int unsigned PAYLOAD_W = 32,
   parameter bit          SKID      = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output logic [1:0]           occupancy
);

   logic                 main_valid_q, skid_valid_q;
   logic [PAYLOAD_W-1:0] main_data_q, skid_data_q;
   logic                 in_xfer, out_xfer;

   // Ready path: registered-only when the skid entry exists
   always_comb begin
      if (SKID) begin
         in_ready = ~skid_valid_q;
      end else begin
         in_ready = ~main_valid_q | out_ready;
      end
   end

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = main_valid_q & out_ready;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

   // Main/skid entry update; skid always drains into main first to keep FIFO order
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else if (flush) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (!main_valid_q || out_xfer) begin
         if (skid_valid_q) begin
            main_data_q  <= skid_data_q;
            main_valid_q <= 1'b1;
            skid_valid_q <= 1'b0;
         end else if (in_xfer) begin
            main_data_q  <= in_data;
            main_valid_q <= 1'b1;
         end else begin
            main_valid_q <= 1'b0;
         end
      end else if (in_xfer) begin
         // Main is stalled, park the new beat
         skid_data_q  <= in_data;
         skid_valid_q <= 1'b1;
      end
   end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake, flush and load-use bubble insertion.
// Optional build macro ID_EX_SKID_EN adds a second (skid) entry and a registered in_ready.
// ctrl_out is a NOP whenever out_valid is low so an empty slot is harmless downstream.
module id_ex_pipe_stage
   import rv_pipe_pkg::*;
#(
   parameter int unsigned XLEN    = rv_pipe_pkg::XLEN,
   parameter int unsigned ADDR_W  = rv_pipe_pkg::ADDR_W,
   parameter int unsigned INST_W  = rv_pipe_pkg::INST_W,
   parameter int unsigned RADDR_W = rv_pipe_pkg::RADDR_W,
   parameter int unsigned CTRL_W  = rv_pipe_pkg::CTRL_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CTRL_W-1:0]  ctrl_in,
   input  logic [XLEN-1:0]    rs1_data_in,
   input  logic [XLEN-1:0]    rs2_data_in,
   input  logic [XLEN-1:0]    imm_in,
   input  logic [ADDR_W-1:0]  pc_in,
   input  logic [INST_W-1:0]  inst_in,
   input  logic [RADDR_W-1:0] rd_in,
   input  logic [RADDR_W-1:0] rs1_in,
   input  logic [RADDR_W-1:0] rs2_in,
   input  logic               flush,
   input  logic               bubble,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  ctrl_out,
   output logic [XLEN-1:0]    rs1_data_out,
   output logic [XLEN-1:0]    rs2_data_out,
   output logic [XLEN-1:0]    imm_out,
   output logic [ADDR_W-1:0]  pc_out,
   output logic [INST_W-1:0]  inst_out,
   output logic [RADDR_W-1:0] rd_out,
   output logic [RADDR_W-1:0] rs1_out,
   output logic [RADDR_W-1:0] rs2_out,
   output logic [1:0]         occupancy
);

   localparam int unsigned DATA_W    = 3 * XLEN + ADDR_W + INST_W + 3 * RADDR_W;
   localparam int unsigned PAYLOAD_W = CTRL_W + DATA_W;

   logic [DATA_W-1:0] data_in;

   assign data_in = {rs1_data_in, rs2_data_in, imm_in, pc_in, inst_in, rd_in, rs1_in, rs2_in};

`ifdef ID_EX_SKID_EN

   logic                 buf_in_ready, buf_in_valid, buf_out_valid;
   logic [PAYLOAD_W-1:0] buf_out_data;
   logic [CTRL_W-1:0]    ctrl_raw;

   assign in_ready     = rst_n & buf_in_ready & ~bubble & ~flush;
   // Bubble/flush gating is already folded into in_ready
   assign buf_in_valid = in_valid & in_ready;

   pipe_skid_buf #(
      .PAYLOAD_W (PAYLOAD_W),
      .SKID      (1'b1)
   ) u_skid_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (buf_in_valid),
      .in_ready  (buf_in_ready),
      .in_data   ({ctrl_in, data_in}),
      .out_valid (buf_out_valid),
      .out_ready (out_ready),
      .out_data  (buf_out_data),
      .occupancy (occupancy)
   );

   assign out_valid = buf_out_valid;
   assign {ctrl_raw, rs1_data_out, rs2_data_out, imm_out, pc_out, inst_out,
           rd_out, rs1_out, rs2_out} = buf_out_data;
   assign ctrl_out  = buf_out_valid ? ctrl_raw : CTRL_NOP;

`else

   logic              valid_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [DATA_W-1:0] data_q;
   logic              in_xfer, out_xfer;

   assign in_ready = rst_n & ~flush & ~bubble & (~valid_q | out_ready);
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = valid_q & out_ready;

   // Single entry: flush > bubble > handshake; ctrl cleared whenever the slot empties
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
         data_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
      end else if (bubble) begin
         // Never overwrite an entry EX has not taken yet
         if (out_ready || !valid_q) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
         end
      end else if (in_xfer) begin
         valid_q <= 1'b1;
         ctrl_q  <= ctrl_in;
         data_q  <= data_in;
      end else if (out_xfer) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_NOP;
      end
   end

   assign out_valid = valid_q;
   assign ctrl_out  = ctrl_q;
   assign {rs1_data_out, rs2_data_out, imm_out, pc_out, inst_out, rd_out, rs1_out, rs2_out} = data_q;
   assign occupancy = {1'b0, valid_q};

`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed self-checking bench for id_ex_pipe_stage (default and ID_EX_SKID_EN builds).
module tb_id_ex_pipe_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  ctrl_in;
   logic [31:0] rs1_data_in, rs2_data_in, imm_in, pc_in, inst_in;
   logic [4:0]  rd_in, rs1_in, rs2_in;
   logic        flush, bubble;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  ctrl_out;
   logic [31:0] rs1_data_out, rs2_data_out, imm_out, pc_out, inst_out;
   logic [4:0]  rd_out, rs1_out, rs2_out;
   logic [1:0]  occupancy;

   int tests = 0;
   int fails = 0;

`ifdef ID_EX_SKID_EN
   localparam logic STALL_READY = 1'b1;
`else
   localparam logic STALL_READY = 1'b0;
`endif

   id_ex_pipe_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ctrl_in      (ctrl_in),
      .rs1_data_in  (rs1_data_in),
      .rs2_data_in  (rs2_data_in),
      .imm_in       (imm_in),
      .pc_in        (pc_in),
      .inst_in      (inst_in),
      .rd_in        (rd_in),
      .rs1_in       (rs1_in),
      .rs2_in       (rs2_in),
      .flush        (flush),
      .bubble       (bubble),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .ctrl_out     (ctrl_out),
      .rs1_data_out (rs1_data_out),
      .rs2_data_out (rs2_data_out),
      .imm_out      (imm_out),
      .pc_out       (pc_out),
      .inst_out     (inst_out),
      .rd_out       (rd_out),
      .rs1_out      (rs1_out),
      .rs2_out      (rs2_out),
      .occupancy    (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one beat whose fields are all derived from its pc
   task automatic offer(input logic [31:0] pc, input logic [5:0] ctrl);
      in_valid    = 1'b1;
      ctrl_in     = ctrl;
      pc_in       = pc;
      inst_in     = pc ^ 32'hDEAD_0000;
      rs1_data_in = pc + 32'h100;
      rs2_data_in = pc + 32'h200;
      imm_in      = pc + 32'h300;
      rd_in       = pc[6:2];
      rs1_in      = pc[6:2] + 5'd1;
      rs2_in      = pc[6:2] + 5'd2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full payload check of a valid beat
   task automatic chk_beat(input string tag, input logic [31:0] pc, input logic [5:0] ctrl);
      logic [4:0] idx;
      idx = pc[6:2];
      chk({tag, ".valid"}, out_valid, 1'b1);
      chk({tag, ".pc"}, pc_out, pc);
      chk({tag, ".ctrl"}, ctrl_out, ctrl);
      chk({tag, ".inst"}, inst_out, pc ^ 32'hDEAD_0000);
      chk({tag, ".rs1d"}, rs1_data_out, pc + 32'h100);
      chk({tag, ".imm"}, imm_out, pc + 32'h300);
      chk({tag, ".rd"}, rd_out, idx);
      chk({tag, ".rs2"}, rs2_out, idx + 5'd2);
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b0;
      bubble    = 1'b0;
      offer(32'hAA, 6'b111111);

      // Reset with a valid beat offered
      tick();
      tick();
      chk("rst.valid", out_valid, 1'b0);
      chk("rst.ctrl", ctrl_out, 6'd0);
      chk("rst.pc", pc_out, 32'd0);
      chk("rst.inst", inst_out, 32'd0);
      chk("rst.rs1d", rs1_data_out, 32'd0);
      chk("rst.rd", rd_out, 5'd0);
      chk("rst.occ", occupancy, 2'd0);
      chk("rst.in_ready", in_ready, 1'b0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick();
      chk("idle.valid", out_valid, 1'b0);

      // Streaming back-to-back
      for (int i = 0; i < 3; i++) begin
         offer(32'(i * 4), 6'b000011);
         #1;
         chk("stream.in_ready", in_ready, 1'b1);
         tick();
         chk_beat("stream", 32'(i * 4), 6'b000011);
         chk("stream.occ", occupancy, 2'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("drain.valid", out_valid, 1'b0);
      chk("drain.ctrl", ctrl_out, 6'd0);
      chk("drain.pc_kept", pc_out, 32'h08);
      chk("drain.occ", occupancy, 2'd0);

      // Backpressure on pc 0x10
      out_ready = 1'b0;
      offer(32'h10, 6'b100000);
      tick();
      chk_beat("bp.load", 32'h10, 6'b100000);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp.in_ready", in_ready, STALL_READY);
         tick();
         chk_beat("bp.hold", 32'h10, 6'b100000);
         chk("bp.occ", occupancy, 2'd1);
      end
      out_ready = 1'b1;
      offer(32'h14, 6'b000001);
      #1;
      chk("bp.release_ready", in_ready, 1'b1);
      tick();
      chk_beat("bp.next", 32'h14, 6'b000001);
      in_valid = 1'b0;
      tick();
      chk("bp.empty", out_valid, 1'b0);

      // Flush kills held 0x20 and offered 0x24
      out_ready = 1'b0;
      offer(32'h20, 6'b000011);
      tick();
      chk_beat("fl.held", 32'h20, 6'b000011);
      offer(32'h24, 6'b000011);
      flush = 1'b1;
      #1;
      chk("fl.in_ready", in_ready, 1'b0);
      tick();
      chk("fl.valid", out_valid, 1'b0);
      chk("fl.ctrl", ctrl_out, 6'd0);
      chk("fl.occ", occupancy, 2'd0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("fl.no_0x24", out_valid, 1'b0);

      // Bubble after a load at 0x30; 0x34 held in ID for one cycle
      offer(32'h30, 6'b011011);
      tick();
      chk_beat("bub.load", 32'h30, 6'b011011);
      offer(32'h34, 6'b000011);
      bubble = 1'b1;
      #1;
      chk("bub.in_ready", in_ready, 1'b0);
      tick();
      chk("bub.valid", out_valid, 1'b0);
      chk("bub.ctrl", ctrl_out, 6'd0);
      bubble = 1'b0;
      #1;
      chk("bub.resume_ready", in_ready, 1'b1);
      tick();
      chk_beat("bub.next", 32'h34, 6'b000011);
      in_valid = 1'b0;
      tick();
      chk("bub.no_dup", out_valid, 1'b0);

      // Bubble must not overwrite an unconsumed entry
      out_ready = 1'b0;
      offer(32'h38, 6'b000011);
      tick();
      in_valid = 1'b0;
      bubble   = 1'b1;
      tick();
      chk_beat("bub.held", 32'h38, 6'b000011);
      bubble    = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bub.held_gone", out_valid, 1'b0);
      chk("bub.held_occ", occupancy, 2'd0);

`ifdef ID_EX_SKID_EN
      // Two entries under stall, drained in order
      out_ready = 1'b0;
      offer(32'h40, 6'b000011);
      #1;
      chk("skid.rdy0", in_ready, 1'b1);
      tick();
      offer(32'h44, 6'b000001);
      #1;
      chk("skid.rdy1", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("skid.occ2", occupancy, 2'd2);
      chk_beat("skid.main", 32'h40, 6'b000011);
      #1;
      chk("skid.full_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      tick();
      chk_beat("skid.second", 32'h44, 6'b000001);
      chk("skid.occ1", occupancy, 2'd1);
      tick();
      chk("skid.empty", out_valid, 1'b0);
      chk("skid.occ0", occupancy, 2'd0);

      // Flush at occupancy 2
      out_ready = 1'b0;
      offer(32'h48, 6'b000011);
      tick();
      offer(32'h4C, 6'b000011);
      tick();
      in_valid = 1'b0;
      chk("skid.fill2", occupancy, 2'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("skid.fl_occ", occupancy, 2'd0);
      chk("skid.fl_valid", out_valid, 1'b0);
      chk("skid.fl_ctrl", ctrl_out, 6'd0);
      out_ready = 1'b1;
      tick();
      chk("skid.fl_stay", out_valid, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
